// File: rtl/cache_pkg.sv
// cache_pkg: tags, filler states and line alignment shared by the L1 miss path.
package cache_pkg;
  localparam int TAG_W = 13;
  localparam logic [TAG_W-1:0] MEM_READ_TAG = 13'h00A5;
  localparam logic [TAG_W-1:0] MEM_WRITE_TAG = 13'h015A;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, FILL} filler_state_t;
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int off);
    return addr & ~((64'd1 << off) - 64'd1);
  endfunction
endpackage

// File: rtl/line_assembler.sv
// line_assembler: beat counter plus indexed line register; clear rewinds the counter only.
module line_assembler #(
  parameter int WIDTH = 64,
  parameter int LINE_BEATS = 8,
  parameter int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        we,
  input  logic [WIDTH-1:0]            din,
  output logic [BW-1:0]               beat,
  output logic [WIDTH*LINE_BEATS-1:0] data
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      beat <= '0;
      data <= '0;
    end else if (clr) begin
      beat <= '0;
    end else if (we) begin
      data[beat*WIDTH +: WIDTH] <= din;
      // hold on the last beat; only clr rewinds the index
      if (beat != BW'(LINE_BEATS - 1)) beat <= beat + BW'(1);
    end
endmodule

// File: rtl/cache_line_filler.sv
// cache_line_filler: blocking L1 miss engine issuing one read burst per miss and
// returning the assembled line, aborting on a per-beat timeout.
module cache_line_filler
  import cache_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_WIDTH = 13,
  parameter int LINE_BEATS = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        miss_valid,
  input  logic [WIDTH-1:0]            miss_addr,
  output logic                        miss_ready,
  output logic                        fill_valid,
  output logic [WIDTH-1:0]            fill_addr,
  output logic [WIDTH*LINE_BEATS-1:0] fill_data,
  input  logic                        fill_ready,
  output logic                        fill_err,
  output logic                        reqcyc,
  output logic [WIDTH-1:0]            req,
  output logic [TAG_WIDTH-1:0]        reqtag,
  input  logic                        reqack,
  input  logic                        respcyc,
  input  logic [WIDTH-1:0]            resp,
  input  logic [TAG_WIDTH-1:0]        resptag,
  output logic [TAG_WIDTH-1:0]        dbg_resptag
);
  localparam int OFF = $clog2(LINE_BEATS * WIDTH / 8);
  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  filler_state_t state;
  logic [TW-1:0] timer;
  logic [BW-1:0] beat;
  logic [WIDTH-1:0] line_addr;
  assign miss_ready = state == IDLE;
  assign line_addr = WIDTH'(line_align(64'(miss_addr), OFF));
  line_assembler #(.WIDTH(WIDTH), .LINE_BEATS(LINE_BEATS), .BW(BW)) u_asm (
    .clk(clk), .reset(reset),
    .clr(state == REQ && reqack),
    .we(state == WAIT && respcyc),
    .din(resp), .beat(beat), .data(fill_data)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      reqcyc <= 1'b0;
      req <= '0;
      reqtag <= '0;
      fill_valid <= 1'b0;
      fill_err <= 1'b0;
      fill_addr <= '0;
      timer <= '0;
      dbg_resptag <= '0;
    end else begin
      fill_err <= 1'b0;
      if (respcyc) dbg_resptag <= resptag;
      case (state)
        IDLE: if (miss_valid) begin
          req <= line_addr;
          fill_addr <= line_addr;
          reqcyc <= 1'b1;
          reqtag <= TAG_WIDTH'(MEM_READ_TAG);
          state <= REQ;
        end
        REQ: if (reqack) begin
          reqcyc <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (respcyc) begin
          timer <= '0;
          if (beat == BW'(LINE_BEATS - 1)) state <= DRAIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          fill_err <= 1'b1;
          state <= IDLE;
        end else begin
          timer <= timer + TW'(1);
        end
        // the arbiter may keep respcyc high past the last beat; wait it out
        DRAIN: if (!respcyc) begin
          fill_valid <= 1'b1;
          state <= FILL;
        end
        FILL: if (fill_ready) begin
          fill_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cache_line_filler.sv
// tb_cache_line_filler: scenario tasks with randomized bursts checked against a line model.
module tb_cache_line_filler;
  import cache_pkg::*;
  localparam int W = 64, TW = 13, LB = 8, TO = 16;
  localparam int OFF = $clog2(LB * W / 8);
  logic clk = 1'b0, reset = 1'b0, miss_valid = 1'b0, fill_ready = 1'b0, reqack = 1'b0, respcyc = 1'b0;
  logic [W-1:0] miss_addr = '0, resp = '0;
  logic [TW-1:0] resptag = '0;
  logic miss_ready, fill_valid, fill_err, reqcyc;
  logic [W-1:0] fill_addr, req;
  logic [W*LB-1:0] fill_data;
  logic [TW-1:0] reqtag, dbg_resptag;
  int n_checks = 0, n_pass = 0, err_pulses = 0;
  logic [W-1:0] beats [LB];
  logic o_ready_idle, o_reqcyc0, o_hold_ok, o_drop, o_early, o_fv, o_stable, o_busy_ok, o_done_ok;
  logic [W-1:0] o_req, o_addr;
  logic [TW-1:0] o_tag;
  logic [W*LB-1:0] o_data;

  cache_line_filler #(.WIDTH(W), .TAG_WIDTH(TW), .LINE_BEATS(LB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_ready(fill_ready), .fill_err(fill_err),
    .reqcyc(reqcyc), .req(req), .reqtag(reqtag), .reqack(reqack),
    .respcyc(respcyc), .resp(resp), .resptag(resptag), .dbg_resptag(dbg_resptag)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (reset && fill_err) err_pulses++;

  function automatic logic [W-1:0] exp_addr(input logic [W-1:0] a);
    return (a >> OFF) << OFF;
  endfunction

  function automatic logic [W*LB-1:0] exp_line();
    logic [W*LB-1:0] l;
    for (int k = 0; k < LB; k++) l[k*W +: W] = beats[k];
    return l;
  endfunction

  task automatic rand_beats();
    for (int k = 0; k < LB; k++) beats[k] = {$urandom, $urandom};
  endtask

  task automatic do_miss(input logic [W-1:0] addr, input int ack_dly, input int gap, input bit rnd_gap,
                         input int trail, input int rdy_dly, input bit second);
    int g;
    o_ready_idle = miss_ready;
    miss_valid = 1'b1;
    miss_addr = addr;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    o_reqcyc0 = reqcyc; o_req = req; o_tag = reqtag; o_hold_ok = 1'b1;
    repeat (ack_dly) begin
      @(posedge clk); #1;
      if (!(reqcyc === 1'b1 && req === o_req && reqtag === o_tag)) o_hold_ok = 1'b0;
    end
    reqack = 1'b1;
    @(posedge clk); #1;
    reqack = 1'b0;
    o_drop = reqcyc;
    o_early = 1'b0;
    for (int k = 0; k < LB; k++) begin
      g = rnd_gap ? int'($urandom_range(gap, 0)) : gap;
      repeat (g) begin @(posedge clk); #1; o_early |= fill_valid; end
      respcyc = 1'b1; resp = beats[k]; resptag = TW'($urandom);
      @(posedge clk); #1;
      o_early |= fill_valid;
      respcyc = 1'b0;
    end
    respcyc = trail > 0;
    repeat (trail) begin
      resp = 64'hDEAD;
      @(posedge clk); #1;
      o_early |= fill_valid;
    end
    respcyc = 1'b0; resp = {$urandom, $urandom};
    @(posedge clk); #1;
    o_fv = fill_valid; o_addr = fill_addr; o_data = fill_data;
    o_stable = 1'b1; o_busy_ok = miss_ready === 1'b0;
    if (second) begin miss_valid = 1'b1; miss_addr = ~addr; end
    repeat (rdy_dly) begin
      @(posedge clk); #1;
      if (!(fill_valid === 1'b1 && fill_addr === o_addr && fill_data === o_data)) o_stable = 1'b0;
      if (!(miss_ready === 1'b0 && reqcyc === 1'b0)) o_busy_ok = 1'b0;
    end
    miss_valid = 1'b0; fill_ready = 1'b1;
    @(posedge clk); #1;
    fill_ready = 1'b0;
    o_done_ok = fill_valid === 1'b0 && miss_ready === 1'b1 && reqcyc === 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (reqcyc !== 1'b0 || fill_valid !== 1'b0 || fill_err !== 1'b0) $display("FAIL reset_ctl got reqcyc=%b fv=%b err=%b want 0 0 0", reqcyc, fill_valid, fill_err); else n_pass++;
    n_checks++; if (req !== '0 || reqtag !== '0 || fill_addr !== '0) $display("FAIL reset_regs got req=%h tag=%h addr=%h want 0", req, reqtag, fill_addr); else n_pass++;
    n_checks++; if (fill_data !== '0) $display("FAIL reset_data got %h want 0", fill_data); else n_pass++;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (miss_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", miss_ready); else n_pass++;
  endtask

  task automatic test_basic();
    logic [W-1:0] a = 64'h1000_0048;
    int e0 = err_pulses;
    for (int k = 0; k < LB; k++) beats[k] = W'((k + 1) * 'h11);
    do_miss(a, 3, 0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (o_ready_idle !== 1'b1 || o_reqcyc0 !== 1'b1) $display("FAIL basic_issue got ready=%b reqcyc=%b want 1 1", o_ready_idle, o_reqcyc0); else n_pass++;
    n_checks++; if (o_req !== 64'h1000_0040) $display("FAIL basic_req got %h want %h", o_req, 64'h1000_0040); else n_pass++;
    n_checks++; if (o_tag !== MEM_READ_TAG) $display("FAIL basic_tag got %h want %h", o_tag, MEM_READ_TAG); else n_pass++;
    n_checks++; if (o_hold_ok !== 1'b1 || o_drop !== 1'b0) $display("FAIL basic_ack got hold=%b after_ack=%b want 1 0", o_hold_ok, o_drop); else n_pass++;
    n_checks++; if (o_fv !== 1'b1 || o_early !== 1'b0) $display("FAIL basic_fv got fv=%b early=%b want 1 0", o_fv, o_early); else n_pass++;
    n_checks++; if (o_addr !== exp_addr(a)) $display("FAIL basic_addr got %h want %h", o_addr, exp_addr(a)); else n_pass++;
    n_checks++; if (o_data !== exp_line()) $display("FAIL basic_data got %h want %h", o_data, exp_line()); else n_pass++;
    n_checks++; if (o_done_ok !== 1'b1 || err_pulses != e0) $display("FAIL basic_done got done=%b errs=%0d want 1 0", o_done_ok, err_pulses - e0); else n_pass++;
  endtask

  task automatic test_gapped();
    int e0 = err_pulses;
    do_miss(64'h1000_0048, 1, 2, 1'b0, 0, 0, 1'b0);
    n_checks++; if (o_data !== exp_line() || o_fv !== 1'b1) $display("FAIL gapped_data got %h fv=%b want %h", o_data, o_fv, exp_line()); else n_pass++;
    n_checks++; if (err_pulses != e0) $display("FAIL gapped_err got %0d pulses want 0", err_pulses - e0); else n_pass++;
  endtask

  task automatic test_trailing();
    rand_beats();
    do_miss(64'h1000_0048, 0, 0, 1'b0, 4, 0, 1'b0);
    n_checks++; if (o_data !== exp_line()) $display("FAIL trail_data got %h want %h", o_data, exp_line()); else n_pass++;
    n_checks++; if (o_early !== 1'b0 || o_fv !== 1'b1) $display("FAIL trail_fv got early=%b fv=%b want 0 1", o_early, o_fv); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a = {$urandom, $urandom};
    rand_beats();
    do_miss(a, 2, 1, 1'b0, 1, 5, 1'b1);
    n_checks++; if (o_stable !== 1'b1) $display("FAIL bp_stable got %b want 1", o_stable); else n_pass++;
    n_checks++; if (o_busy_ok !== 1'b1) $display("FAIL bp_busy got %b want 1", o_busy_ok); else n_pass++;
    n_checks++; if (o_done_ok !== 1'b1) $display("FAIL bp_done got %b want 1", o_done_ok); else n_pass++;
    n_checks++; if (o_addr !== exp_addr(a) || o_data !== exp_line()) $display("FAIL bp_line got %h want %h", o_addr, exp_addr(a)); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      rand_beats();
      do_miss(a, $urandom_range(5, 0), 6, 1'b1, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
      n_checks++; if (o_req !== exp_addr(a) || o_addr !== exp_addr(a)) $display("FAIL rand_addr[%0d] got req=%h fill=%h want %h", i, o_req, o_addr, exp_addr(a)); else n_pass++;
      n_checks++; if (o_data !== exp_line() || o_fv !== 1'b1 || o_early !== 1'b0) $display("FAIL rand_data[%0d] got %h fv=%b want %h", i, o_data, o_fv, exp_line()); else n_pass++;
      n_checks++; if (o_stable !== 1'b1 || o_busy_ok !== 1'b1 || o_done_ok !== 1'b1) $display("FAIL rand_hs[%0d] got %b%b%b want 111", i, o_stable, o_busy_ok, o_done_ok); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int e0 = err_pulses;
    logic [W*LB-1:0] d = fill_data;
    miss_valid = 1'b1; miss_addr = {$urandom, $urandom};
    @(posedge clk); #1;
    miss_valid = 1'b0; reqack = 1'b1;
    @(posedge clk); #1;
    reqack = 1'b0;
    while (fill_err !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    n_checks++; if (n != TO) $display("FAIL timeout_lat got %0d cycles want %0d", n, TO); else n_pass++;
    n_checks++; if (fill_valid !== 1'b0 || miss_ready !== 1'b1) $display("FAIL timeout_idle got fv=%b ready=%b want 0 1", fill_valid, miss_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (fill_err !== 1'b0 || err_pulses - e0 != 1) $display("FAIL timeout_pulse got err=%b pulses=%0d want 0 1", fill_err, err_pulses - e0); else n_pass++;
    respcyc = 1'b1;
    repeat (3) begin resp = {$urandom, $urandom}; @(posedge clk); #1; end
    respcyc = 1'b0;
    n_checks++; if (fill_data !== d || fill_valid !== 1'b0) $display("FAIL idle_beats got %h want %h", fill_data, d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    miss_valid = 1'b1; miss_addr = 64'h3000_0010;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (reqcyc !== 1'b0 || req !== '0) $display("FAIL rst_req got reqcyc=%b req=%h want 0 0", reqcyc, req); else n_pass++;
    @(posedge clk); #1; reset = 1'b1;
    miss_valid = 1'b1; miss_addr = 64'h3000_0010;
    @(posedge clk); #1;
    miss_valid = 1'b0; reqack = 1'b1;
    @(posedge clk); #1;
    reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      respcyc = 1'b1; resp = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    respcyc = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (reqcyc !== 1'b0 || fill_valid !== 1'b0 || fill_data !== '0) $display("FAIL rst_wait got reqcyc=%b fv=%b data=%h want 0 0 0", reqcyc, fill_valid, fill_data); else n_pass++;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (miss_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", miss_ready); else n_pass++;
    rand_beats();
    do_miss(64'h2000, 1, 1, 1'b1, 0, 1, 1'b0);
    n_checks++; if (o_addr !== 64'h2000 || o_data[W-1:0] !== beats[0]) $display("FAIL rst_refill got addr=%h beat0=%h want 2000 %h", o_addr, o_data[W-1:0], beats[0]); else n_pass++;
    n_checks++; if (o_data !== exp_line() || o_done_ok !== 1'b1) $display("FAIL rst_line got %h want %h", o_data, exp_line()); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t want completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_trailing();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cache_line_filler.md
Name: cache_line_filler

Overview:
- Cache-side miss engine sitting directly upstream of the arbiter, one instance per L1 (icache, dcache).
- Accepts a single line-miss request from the cache controller and issues one read burst on the arbiter cache interface.
- Collects LINE_BEATS response beats of WIDTH bits each, then presents the assembled line to the cache for refill.
- Blocking design: only one miss is outstanding at a time.

Parameters:
- WIDTH, 64, address and data beat width in bits.
- TAG_WIDTH, 13, width of the request and response tags on the arbiter interface.
- LINE_BEATS, 8, beats per cache line. Must be a power of two.
- TIMEOUT, 1024, maximum number of cycles allowed between request acceptance and each beat before the miss is aborted.

Ports:
- clk  in  1  clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- miss_valid  in  1  cache requests a line fill.
- miss_addr  in  WIDTH  miss byte address. Offset bits are ignored.
- miss_ready  out  1  filler can accept a miss.
- fill_valid  out  1  assembled line available.
- fill_addr  out  WIDTH  line-aligned address of the line in fill_data.
- fill_data  out  WIDTH*LINE_BEATS  line data; beat k occupies bits [k*WIDTH +: WIDTH].
- fill_ready  in  1  cache consumed the fill.
- fill_err  out  1  one-cycle pulse: miss aborted on timeout.
- reqcyc  out  1  request valid to the arbiter.
- req  out  WIDTH  line-aligned request address.
- reqtag  out  TAG_WIDTH  request tag. Always MEM_READ_TAG.
- reqack  in  1  arbiter accepted the request.
- respcyc  in  1  response beat valid.
- resp  in  WIDTH  response data beat.
- resptag  in  TAG_WIDTH  response tag. Captured for debug only.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE. reqcyc=0, req=0, reqtag=0, fill_valid=0, fill_err=0, fill_addr=0, fill_data=0, beat counter=0, timer=0. miss_ready=1 once reset is released.
- Offset bits: OFF = log2(LINE_BEATS*WIDTH/8); the default configuration gives 6. Line address = miss_addr with the low OFF bits forced to 0.
- IDLE: miss_ready=1 (combinational, state==IDLE). On miss_valid: latch the line address into req and fill_addr, drive reqcyc=1 and reqtag=MEM_READ_TAG on the next cycle, go to REQ.
- REQ: hold reqcyc, req and reqtag stable until reqack is sampled 1. Then in the same edge: reqcyc<=0, timer<=0, beat<=0, go to WAIT.
  - reqcyc is never dropped before reqack.
  - There is no timeout in REQ; arbiter starvation is legal.
- WAIT: every cycle with respcyc==1 is one beat. Store resp into fill_data[beat*WIDTH +: WIDTH], increment beat, clear timer.
  - On the beat where beat==LINE_BEATS-1: go to DRAIN.
  - Each cycle without respcyc: timer increments.
  - If timer reaches TIMEOUT-1 without a beat: pulse fill_err for one cycle, go to IDLE. Partial data is discarded and fill_valid stays 0.
- DRAIN: ignore respcyc/resp. The arbiter holds respcyc high after the final beat until its own burst completes. Leave DRAIN on the first cycle respcyc==0: set fill_valid=1, go to FILL. This prevents stale beats corrupting the next miss.
- FILL: fill_valid, fill_addr and fill_data held stable until fill_ready is sampled 1. Then fill_valid<=0, go to IDLE.
  - fill_ready may already be high on the first FILL cycle, giving a one-cycle fill_valid pulse.
- Beat counter width: log2(LINE_BEATS) bits. Beat index wraps to 0 only via an explicit clear.
- Beats arriving outside WAIT/DRAIN are ignored and do not touch fill_data.
- Minimum latency: miss_valid to reqcyc = 1 cycle. Last beat to fill_valid = at least 1 cycle, pending the respcyc low cycle.
- Reset mid-burst: everything returns to reset values immediately. reqcyc drops asynchronously. Arbiter recovery is out of scope for this block.
- miss_valid outside IDLE is ignored. The cache holds it until miss_ready.

Decomposition:
- Shared package cache_pkg holds:
  - MEM_READ_TAG and MEM_WRITE_TAG constants, TAG_WIDTH wide.
  - filler_state_t enum {IDLE, REQ, WAIT, DRAIN, FILL}.
  - Function line_align(addr, OFF).
- Natural sub-module: line_assembler (beat counter plus a WIDTH*LINE_BEATS shift/indexed register with a clear input).
- The FSM and timer stay in cache_line_filler.

Test Plan:
- Basic fill: miss_addr=0x1000_0048, reqack after 3 cycles, 8 back-to-back beats 0x11..0x88, respcyc low after the 8th beat → req=0x1000_0040, reqcyc drops the cycle after reqack, fill_data beat0=0x11 … beat7=0x88, fill_valid asserted one cycle after respcyc falls.
- Gapped beats: same miss, 2 idle cycles between each beat → identical fill_data, no fill_err.
- Trailing respcyc: respcyc held high 4 extra cycles after the 8th beat with resp=0xDEAD → fill_data unchanged. fill_valid only after respcyc drops.
- Backpressure: fill_ready low for 5 cycles → fill_valid, fill_addr and fill_data stable for those cycles. miss_ready=0 until one cycle after fill_ready. A second miss issued during FILL is not accepted early.
- Timeout: TIMEOUT=16, reqack given, no beats → fill_err pulses exactly once 16 cycles after acceptance. State returns to IDLE, fill_valid never asserts.
- Async reset mid-WAIT after 4 beats → reqcyc=0, fill_valid=0, miss_ready=1 after release. A new miss at 0x2000 then fills correctly with beat0 at fill_data[63:0].
